// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
//   Shared constants for the load/store unit: RV32I opcode and funct3 codes,
//   word/enable constants, the access-size type and small decode helpers used
//   by mem_access and mem_lane_align.
// -----------------------------------------------------------------------------
package mem_access_pkg;

  // Opcodes handled by the load/store unit.
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  // Load funct3 codes.
  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;

  // Store funct3 codes.
  localparam logic [2:0] INST_SB = 3'b000;
  localparam logic [2:0] INST_SH = 3'b001;
  localparam logic [2:0] INST_SW = 3'b010;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;

  // Access size is encoded in funct3[1:0] for both loads and stores
  // (funct3[2] only selects zero- vs sign-extension on loads).
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  function automatic size_e size_of(input logic [2:0] funct3);
    size_e sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // True for the load/store encodings this unit executes.
  function automatic logic inst_legal(input logic [6:0] opcode,
                                      input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (opcode == INST_TYPE_L)
      legal = funct3 inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
    else if (opcode == INST_TYPE_S)
      legal = funct3 inside {INST_SB, INST_SH, INST_SW};
    return legal;
  endfunction

  // True when the byte offset does not fit the natural alignment of the size.
  function automatic logic inst_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic mis;
    case (size_of(funct3))
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage : mem_access_pkg

// File: rtl/mem_access_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane logic for the load/store unit.
//   Store side: builds the byte strobes and lane-replicated write data.
//   Load side : selects the addressed byte/halfword from the bus word and
//               sign- or zero-extends it.
//   Ports:
//     funct3   in   3  access size / signedness
//     offset   in   2  effective address [1:0]
//     st_data  in  32  rs2 store data
//     ld_raw   in  32  raw bus read word
//     wstrb    out  4  byte write strobes
//     wdata    out 32  replicated store data
//     ld_data  out 32  extracted and extended load data
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store packing. Misaligned offsets simply lose their low bits here:
  // a halfword only looks at offset[1], a word ignores the offset entirely.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    wstrb = 4'b0000;
    wdata = ZeroWord;
    case (size_of(funct3))
      SZ_BYTE: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        wstrb = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load lane selection.
  always_comb begin
    ld_byte = ld_raw[7:0];
    case (offset)
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      2'd3:    ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
    ld_half = offset[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  // Load extension.
  always_comb begin
    ld_data = ld_raw;
    case (funct3)
      INST_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      INST_LBU: ld_data = {24'h000000, ld_byte};
      INST_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      INST_LHU: ld_data = {16'h0000, ld_half};
      default:  ld_data = ld_raw;
    endcase
  end

endmodule : mem_lane_align

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Load/store unit behind the execute stage. Accepts one RV32I load/store at a
//   time, runs a single data-bus transaction for it, holds the pipeline while
//   the access is outstanding and produces the load write-back pulse.
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     When defined, misaligned accesses make no bus request; instead the unit
//     reports misalign_o / misalign_addr_o for one cycle. When undefined the
//     access proceeds with the low address bits dropped.
//
//   Ports:
//     clk, rst_n           clock (rising edge), synchronous active-low reset
//     mem_valid_i          execute presents an instruction
//     mem_opcode_i/funct3  instruction decode fields
//     mem_addr_i           effective address
//     mem_rs2_data_i       store data
//     mem_rd_addr_i        load destination
//     bus_req_o/we/addr/wstrb/wdata   data-bus request (held until bus_gnt_i)
//     bus_gnt_i            request accepted
//     bus_rvalid_i/rdata_i read response
//     mem_hold_o           stall request to the control unit
//     wb_en_o/addr/data    load write-back (one-cycle pulse)
//     misalign_o/addr_o    misaligned access report (MEM_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // fixed at 32 for RV32I; lane logic assumes it
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  input  logic [6:0]        mem_opcode_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_rs2_data_i,
  input  logic [4:0]        mem_rd_addr_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              mem_hold_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;

  // Fields latched from execute in the accept cycle.
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              is_store_q;
  logic [DATA_W-1:0] rs2_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rdata_q;     // extracted load data, captured on rvalid

  logic              accept;
  logic              trap_now;    // accepted access is routed to the trap path
  logic              trap_done;   // DONE belongs to a trapped access

  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_ld_data;

  assign accept = (state_q == IDLE) && mem_valid_i &&
                  inst_legal(mem_opcode_i, mem_funct3_i);

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap_q;
  assign trap_now  = accept && inst_misaligned(mem_funct3_i, mem_addr_i[1:0]);
  assign trap_done = trap_q;
`else
  assign trap_now  = 1'b0;
  assign trap_done = 1'b0;
`endif

  // The aligner always works from the latched fields, so strobes and data are
  // stable for the whole REQ phase and extraction matches the latched offset.
  mem_lane_align u_lane_align (
    .funct3  (funct3_q),
    .offset  (addr_q[1:0]),
    .st_data (rs2_q),
    .ld_raw  (bus_rdata_i),
    .wstrb   (lane_wstrb),
    .wdata   (lane_wdata),
    .ld_data (lane_ld_data)
  );

  // Next-state logic. gnt is only looked at in REQ and rvalid only in WAIT,
  // which is what makes stray handshakes in other states harmless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)       state_d = trap_now ? DONE : REQ;
      REQ:  if (bus_gnt_i)    state_d = is_store_q ? DONE : WAIT;
      WAIT: if (bus_rvalid_i) state_d = DONE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
      rs2_q      <= '0;
      rd_q       <= 5'd0;
      rdata_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= mem_addr_i;
        funct3_q   <= mem_funct3_i;
        is_store_q <= (mem_opcode_i == INST_TYPE_S);
        rs2_q      <= mem_rs2_data_i;
        rd_q       <= mem_rd_addr_i;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_q     <= trap_now;
`endif
      end
      if ((state_q == WAIT) && bus_rvalid_i)
        rdata_q <= lane_ld_data;
    end
  end

  // Outputs decode from state. Everything is gated by rst_n so a synchronous
  // reset silences the bus and write-back in the very cycle it is asserted.
  always_comb begin
    bus_req_o   = Disable;
    bus_we_o    = Disable;
    bus_addr_o  = '0;
    bus_wstrb_o = 4'b0000;
    bus_wdata_o = '0;
    mem_hold_o  = Disable;
    wb_en_o     = Disable;
    wb_addr_o   = 5'd0;
    wb_data_o   = '0;
    if (rst_n) begin
      mem_hold_o = accept || (state_q == REQ) || (state_q == WAIT);
      if (state_q == REQ) begin
        bus_req_o  = Enable;
        bus_we_o   = is_store_q;
        bus_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
        if (is_store_q) begin
          bus_wstrb_o = lane_wstrb;
          bus_wdata_o = lane_wdata;
        end
      end
      // Loads to x0 still access the bus but never write back.
      if ((state_q == DONE) && !is_store_q && (rd_q != 5'd0) && !trap_done) begin
        wb_en_o   = Enable;
        wb_addr_o = rd_q;
        wb_data_o = rdata_q;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_o      = Disable;
    misalign_addr_o = '0;
    if (rst_n && (state_q == DONE) && trap_q) begin
      misalign_o      = Enable;
      misalign_addr_o = addr_q;
    end
  end
`endif

endmodule : mem_access

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//   Self-checking bench for mem_access. A scripted driver issues transactions
//   with chosen grant/rvalid delays and, from the instruction alone, states what
//   every output must be in each cycle; a compare process checks the DUT on the
//   falling edge. Directed cases pin the model with literal values, then a
//   randomized run mixes legal, illegal, aligned and misaligned accesses.
//   Honours MEM_MISALIGN_TRAP_EN when the RTL is built with it.
// -----------------------------------------------------------------------------
module tb_mem_access;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic        mem_valid_i;
  logic [6:0]  mem_opcode_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_rs2_data_i;
  logic [4:0]  mem_rd_addr_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        mem_hold_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid_i    (mem_valid_i),
    .mem_opcode_i   (mem_opcode_i),
    .mem_funct3_i   (mem_funct3_i),
    .mem_addr_i     (mem_addr_i),
    .mem_rs2_data_i (mem_rs2_data_i),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wstrb_o    (bus_wstrb_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i),
    .mem_hold_o     (mem_hold_o),
    .wb_en_o        (wb_en_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o     (misalign_o),
    .misalign_addr_o(misalign_addr_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, written by the driver.
  logic        chk_en = 1'b0;
  logic        exp_hold, exp_req, exp_we, exp_wb_en, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data, exp_mis_addr;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_wb_addr;
  int          exp_wb_cnt = 0;

  // Observations recorded from the DUT for the literal checks.
  int          wb_pulses = 0;
  int          req_cycles = 0;
  int          mis_pulses = 0;
  logic [31:0] last_req_addr, last_wdata, last_wb_data, last_mis_addr;
  logic [3:0]  last_wstrb;
  logic [4:0]  last_wb_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model --------------------------------------
  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_L) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (op == OP_S) return (f3 <= 3'd2);
    return 1'b0;
  endfunction

  function automatic int m_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Byte offset actually used: the address rounded down to the access size.
  function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
    int n = m_bytes(f3);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int n = m_bytes(f3);
    return 4'(((1 << n) - 1) << m_off(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = m_bytes(f3);
    if (n == 1) return {24'h0, rs2[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'h0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int n = m_bytes(f3);
    logic [31:0] v, mask;
    v = rdata >> (8 * m_off(f3, addr));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- compare process ----------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("hold", {31'b0, mem_hold_o}, {31'b0, exp_hold});
        check("bus_req", {31'b0, bus_req_o}, {31'b0, exp_req});
        if (exp_req) begin
          check("bus_we", {31'b0, bus_we_o}, {31'b0, exp_we});
          check("bus_addr", bus_addr_o, exp_addr);
          if (exp_we) begin
            check("bus_wstrb", {28'b0, bus_wstrb_o}, {28'b0, exp_wstrb});
            check("bus_wdata", bus_wdata_o, exp_wdata);
          end
        end
        check("wb_en", {31'b0, wb_en_o}, {31'b0, exp_wb_en});
        if (exp_wb_en) begin
          check("wb_addr", {27'b0, wb_addr_o}, {27'b0, exp_wb_addr});
          check("wb_data", wb_data_o, exp_wb_data);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
        if (exp_mis) check("misalign_addr", misalign_addr_o, exp_mis_addr);
        if (misalign_o) begin
          mis_pulses++;
          last_mis_addr = misalign_addr_o;
        end
`endif
      end
      if (bus_req_o) begin
        req_cycles++;
        last_req_addr = bus_addr_o;
        last_wstrb    = bus_wstrb_o;
        last_wdata    = bus_wdata_o;
      end
      if (wb_en_o) begin
        wb_pulses++;
        last_wb_addr = wb_addr_o;
        last_wb_data = wb_data_o;
      end
    end
  end

  // ---------------- driver helpers -----------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    mem_valid_i  = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = $urandom;
    exp_hold = 0; exp_req = 0; exp_we = 0; exp_wb_en = 0; exp_mis = 0;
    exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_wb_addr = '0;
    exp_wb_data = '0; exp_mis_addr = '0;
  endtask

  task automatic pick_illegal(output logic [6:0] op, output logic [2:0] f3);
    case ($urandom % 3)
      0: begin op = 7'b0110011; f3 = 3'($urandom); end
      1: begin
        op = OP_L;
        case ($urandom % 3) 0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7; endcase
      end
      default: begin op = OP_S; f3 = 3'($urandom_range(3, 7)); end
    endcase
  endtask

  // A random instruction presented while the unit is busy; it must be ignored.
  task automatic busy_noise();
    mem_valid_i    = 1'($urandom);
    mem_opcode_i   = ($urandom % 2) ? OP_L : OP_S;
    mem_funct3_i   = 3'($urandom % 3);
    mem_addr_i     = $urandom;
    mem_rs2_data_i = $urandom;
    mem_rd_addr_i  = 5'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      pick_illegal(mem_opcode_i, mem_funct3_i);
      mem_valid_i    = 1'($urandom);
      mem_addr_i     = $urandom;
      mem_rs2_data_i = $urandom;
      mem_rd_addr_i  = 5'($urandom);
      bus_gnt_i      = 1'($urandom);
      bus_rvalid_i   = 1'($urandom);
    end
  endtask

  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
    bit legal, store, trap;
    legal = m_legal(op, f3);
    store = (op == OP_S);
    trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = legal && m_misaligned(f3, addr);
`endif
    // accept cycle
    step();
    mem_valid_i = 1'b1; mem_opcode_i = op; mem_funct3_i = f3;
    mem_addr_i = addr; mem_rs2_data_i = rs2; mem_rd_addr_i = rd;
    bus_gnt_i = 1'($urandom); bus_rvalid_i = 1'($urandom);
    exp_hold = legal;
    if (!legal) return;
    if (!trap) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        step();
        busy_noise();
        bus_gnt_i    = (k == gnt_dly);
        bus_rvalid_i = 1'($urandom);
        exp_hold = 1; exp_req = 1; exp_we = store;
        exp_addr = addr & ~32'h3;
        if (store) begin
          exp_wstrb = m_wstrb(f3, addr);
          exp_wdata = m_wdata(f3, rs2);
        end
      end
      if (!store) begin
        for (int k = 0; k <= rv_dly; k++) begin
          step();
          busy_noise();
          bus_gnt_i    = 1'($urandom);
          bus_rvalid_i = (k == rv_dly);
          if (k == rv_dly) bus_rdata_i = rdata;
          exp_hold = 1;
        end
      end
    end
    // completion cycle
    step();
    busy_noise();
    bus_gnt_i = 1'($urandom);
    exp_wb_en    = !store && (rd != 5'd0) && !trap;
    exp_wb_addr  = rd;
    exp_wb_data  = m_load(f3, addr, rdata);
    exp_mis      = trap;
    exp_mis_addr = addr;
    if (exp_wb_en) exp_wb_cnt++;
  endtask

  // ---------------- stimulus ------------------------------------------------
  int pulses_before, req_before, mis_before;

  initial begin
    rst_n = 1'b0;
    mem_valid_i = 0; mem_opcode_i = '0; mem_funct3_i = '0; mem_addr_i = '0;
    mem_rs2_data_i = '0; mem_rd_addr_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;

    // Reset: outputs must be quiet.
    step(); chk_en = 1'b1;
    step();
    step(); rst_n = 1'b1;
    idle(2);

    // SB to byte 3.
    run_txn(OP_S, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd9, 0, 0, '0);
    idle(1);
    check("sb_addr",  last_req_addr, 32'h0000_1000);
    check("sb_wstrb", {28'b0, last_wstrb}, 32'h0000_0008);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    // LB / LBU / LH sign and zero extension.
    run_txn(OP_L, 3'd0, 32'h0000_2001, '0, 5'd5, 0, 0, 32'h1234_80FF);
    idle(1);
    check("lb_wb_addr", {27'b0, last_wb_addr}, 32'd5);
    check("lb_wb_data", last_wb_data, 32'hFFFF_FF80);
    run_txn(OP_L, 3'd4, 32'h0000_2001, '0, 5'd5, 0, 0, 32'h1234_80FF);
    idle(1);
    check("lbu_wb_data", last_wb_data, 32'h0000_0080);
    run_txn(OP_L, 3'd1, 32'h0000_2002, '0, 5'd6, 0, 0, 32'h8001_0000);
    idle(1);
    check("lh_wb_data", last_wb_data, 32'hFFFF_8001);

    // LW to x0: bus access happens, no write-back.
    pulses_before = wb_pulses;
    req_before    = req_cycles;
    run_txn(OP_L, 3'd2, 32'h0000_2004, '0, 5'd0, 0, 0, 32'hDEAD_BEEF);
    idle(1);
    check("lw_x0_req_cycles", 32'(req_cycles - req_before), 32'd1);
    check("lw_x0_no_wb", 32'(wb_pulses - pulses_before), 32'd0);

    // Stretched handshake: gnt after 3 cycles, rvalid 2 cycles later.
    pulses_before = wb_pulses;
    run_txn(OP_L, 3'd5, 32'h0000_4006, '0, 5'd12, 3, 2, 32'hC3A5_0011);
    idle(1);
    check("slow_req_cycles", 32'(req_cycles - req_before), 32'd5);
    check("slow_one_pulse", 32'(wb_pulses - pulses_before), 32'd1);
    check("slow_lhu_data", last_wb_data, 32'h0000_C3A5);

    // Reset during WAIT, stale rvalid afterwards.
    pulses_before = wb_pulses;
    step();
    mem_valid_i = 1; mem_opcode_i = OP_L; mem_funct3_i = 3'd2;
    mem_addr_i = 32'h0000_5000; mem_rd_addr_i = 5'd7;
    exp_hold = 1;
    step(); bus_gnt_i = 1;
    exp_hold = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h0000_5000;
    step(); exp_hold = 1;
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; bus_rvalid_i = 1; bus_rdata_i = 32'h1111_2222;
    idle(3);
    check("reset_no_wb", 32'(wb_pulses - pulses_before), 32'd0);

    // Misaligned LW.
    req_before = req_cycles;
    mis_before = mis_pulses;
    run_txn(OP_L, 3'd2, 32'h0000_3002, '0, 5'd3, 0, 0, 32'h0BAD_F00D);
    idle(1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_no_req", 32'(req_cycles - req_before), 32'd0);
    check("mis_pulse", 32'(mis_pulses - mis_before), 32'd1);
    check("mis_addr", last_mis_addr, 32'h0000_3002);
`else
    check("mis_lw_addr", last_req_addr, 32'h0000_3000);
    check("mis_lw_data", last_wb_data, 32'h0BAD_F00D);
`endif

    // Randomized run.
    for (int t = 0; t < 400; t++) begin
      logic [6:0] op;
      logic [2:0] f3;
      if ($urandom % 10 == 0) begin
        pick_illegal(op, f3);
      end else if ($urandom % 2) begin
        op = OP_S; f3 = 3'($urandom % 3);
      end else begin
        op = OP_L;
        case ($urandom % 5) 0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5; endcase
      end
      run_txn(op, f3, $urandom, $urandom, 5'($urandom), int'($urandom % 4),
              int'($urandom % 4), $urandom);
      idle(int'($urandom % 3));
    end

    idle(2);
    check("wb_pulse_total", wb_pulses, exp_wb_cnt);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_access
